// File: rtl/fp_to_int_pkg.sv
// Shared types and constants for the binary32-to-integer pipeline.
// Stage payload carries the value, flags, mode bits and decode side-band.
package fp_to_int_pkg;

    localparam int VW = 66;

    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_NX  = 0;

    localparam logic RM_RTZ = 1'b0;
    localparam logic RM_RNE = 1'b1;

    typedef enum logic [1:0] {
        CLS_FIN,
        CLS_NAN,
        CLS_INF,
        CLS_BIG
    } cls_e;

    typedef struct packed {
        logic [VW-1:0] value;
        logic [2:0]    flags;
        logic          neg;
        cls_e          cls;
        logic [9:0]    expo;
        logic          is_signed;
        logic          rne;
    } stage_t;

endpackage

// File: rtl/fp_to_int_stage.sv
// One enable-gated payload-plus-valid pipeline register.
module fp_to_int_stage
    import fp_to_int_pkg::*;
(
    input  logic   clk,
    input  logic   areset,
    input  logic   i_en,
    input  logic   i_valid,
    input  stage_t i_p,
    output logic   o_valid,
    output stage_t o_p
);

    stage_t r_p;
    logic   r_valid;

    always_ff @(posedge clk) begin
        if (areset) begin
            r_valid <= 1'b0;
            r_p     <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_p     <= i_p;
        end
    end

    assign o_valid = r_valid;
    assign o_p     = r_p;

endmodule

// File: rtl/fp_to_int_pipe.sv
// binary32 to signed/unsigned integer converter with a stallable
// valid/ready pipeline of LATENCY registered stages.
module fp_to_int_pipe
    import fp_to_int_pkg::*;
#(
    parameter int OUT_WIDTH = 33,
    parameter int LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_a,
    input  logic                 in_signed,
    input  logic                 in_rne,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_q,
    output logic [2:0]           out_flags
);

    localparam int W      = OUT_WIDTH;
    localparam int SR_AT  = (LATENCY >= 2) ? 1 : 0;
    localparam int SAT_AT = (LATENCY >= 3) ? 2 : LATENCY - 1;

    function automatic stage_t f_decode(input logic [31:0] a,
                                        input logic sm,
                                        input logic rm);
        stage_t p;
        p               = '0;
        p.neg           = a[31];
        p.is_signed     = sm;
        p.rne           = rm;
        p.expo          = {2'b00, a[30:23]} - 10'd127;
        p.value[23:0]   = {(a[30:23] != 8'd0), a[22:0]};
        if (a[30:23] == 8'hFF)
            p.cls = (a[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        else
            p.cls = CLS_FIN;
        return p;
    endfunction

    // Integer part plus guard/sticky; huge exponents skip the shifter.
    function automatic stage_t f_round(input stage_t d);
        stage_t       p;
        int           ei;
        logic [W+23:0] x;
        logic [W:0]   ip;
        logic         g;
        logic         s;
        logic         inc;
        logic [W+1:0] m;
        p  = d;
        ei = int'($signed(d.expo));
        x  = '0;
        ip = '0;
        g  = 1'b0;
        s  = 1'b0;
        if (d.cls == CLS_FIN) begin
            if (ei >= W + 1) begin
                p.cls = CLS_BIG;
            end else if (ei >= 0) begin
                x  = {{W{1'b0}}, d.value[23:0]} << ei;
                ip = x[W+23:23];
                g  = x[22];
                s  = |x[21:0];
            end else if (ei == -1) begin
                g = d.value[23];
                s = |d.value[22:0];
            end else begin
                s = |d.value[23:0];
            end
        end
        inc = (d.rne == RM_RNE) & g & (s | ip[0]);
        m   = {1'b0, ip} + {{(W+1){1'b0}}, inc};
        p.value          = '0;
        p.value[W+1:0]   = m;
        p.flags          = '0;
        p.flags[FLAG_NX] = g | s;
        return p;
    endfunction

    function automatic stage_t f_sat(input stage_t r);
        stage_t       p;
        logic [W+1:0] one;
        logic [W+1:0] m;
        logic [W+1:0] smag;
        logic [W+1:0] smax;
        logic [W+1:0] umax;
        logic [W-1:0] maxq;
        logic [W-1:0] minq;
        logic [W-1:0] q;
        logic         over;
        logic [2:0]   fl;
        one  = {{(W+1){1'b0}}, 1'b1};
        m    = r.value[W+1:0];
        smag = one << (W - 1);
        smax = smag - one;
        umax = (one << W) - one;
        maxq = r.is_signed ? smax[W-1:0] : umax[W-1:0];
        minq = r.is_signed ? smag[W-1:0] : '0;
        if (r.neg)
            over = r.is_signed ? (m > smag) : (m != '0);
        else
            over = m > (r.is_signed ? smax : umax);
        q = r.neg ? (~m[W-1:0] + {{(W-1){1'b0}}, 1'b1}) : m[W-1:0];
        fl          = '0;
        fl[FLAG_NX] = r.flags[FLAG_NX];
        if (r.cls == CLS_NAN) begin
            q            = maxq;
            fl           = '0;
            fl[FLAG_INV] = 1'b1;
        end else if ((r.cls != CLS_FIN) || over) begin
            q            = r.neg ? minq : maxq;
            fl           = '0;
            fl[FLAG_INV] = 1'b1;
            fl[FLAG_OVF] = 1'b1;
        end
        p            = r;
        p.value      = '0;
        p.value[W-1:0] = q;
        p.flags      = fl;
        return p;
    endfunction

    logic   w_en;
    stage_t w_d [LATENCY];
    logic   w_v [LATENCY];

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        stage_t w_t0;
        stage_t w_t1;
        stage_t w_t2;
        logic   w_vin;

        if (k == 0) begin : g_first
            assign w_t0  = f_decode(in_a, in_signed, in_rne);
            assign w_vin = in_valid;
        end else begin : g_next
            assign w_t0  = w_d[k-1];
            assign w_vin = w_v[k-1];
        end

        if (k == SR_AT) begin : g_sr
            assign w_t1 = f_round(w_t0);
        end else begin : g_sr_pass
            assign w_t1 = w_t0;
        end

        if (k == SAT_AT) begin : g_sat
            assign w_t2 = f_sat(w_t1);
        end else begin : g_sat_pass
            assign w_t2 = w_t1;
        end

        fp_to_int_stage u_stage (
            .clk     (clk),
            .areset  (areset),
            .i_en    (w_en),
            .i_valid (w_vin),
            .i_p     (w_t2),
            .o_valid (w_v[k]),
            .o_p     (w_d[k])
        );
    end

    assign out_valid = w_v[LATENCY-1];
    assign out_q     = w_d[LATENCY-1].value[W-1:0];
    assign out_flags = w_d[LATENCY-1].flags;

    logic w_unused;
    assign w_unused = ^{w_d[LATENCY-1].value[VW-1:W],
                        w_d[LATENCY-1].neg,
                        w_d[LATENCY-1].cls,
                        w_d[LATENCY-1].expo,
                        w_d[LATENCY-1].is_signed,
                        w_d[LATENCY-1].rne};

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Bench for fp_to_int_pipe: directed vectors, latency, stall, reset
// and random traffic against a real-arithmetic reference model.
module tb_fp_to_int_pipe;

    localparam int W = 33;

    logic         clk = 1'b0;
    logic         areset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_a;
    logic         in_signed;
    logic         in_rne;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_q;
    logic [2:0]   out_flags;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q [$];

    always #5 clk = ~clk;

    fp_to_int_pipe #(.OUT_WIDTH(W), .LATENCY(3)) dut (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_signed (in_signed),
        .in_rne    (in_rne),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_flags (out_flags)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Value of the float as a real, rounded, then clamped to the range.
    function automatic logic [35:0] model(input logic [31:0] a,
                                          input bit sg, input bit rn);
        int          ex;
        real         mag, ip, fr, rv, v, hi, lo;
        logic [2:0]  fl;
        logic [63:0] t;
        hi = sg ? (2.0 ** 32) - 1.0 : (2.0 ** 33) - 1.0;
        lo = sg ? -(2.0 ** 32) : 0.0;
        ex = int'(a[30:23]);
        if (ex == 0)
            mag = real'(a[22:0]) * (2.0 ** (-149.0));
        else
            mag = real'({1'b1, a[22:0]}) * (2.0 ** real'(ex - 150));
        ip = $floor(mag);
        fr = mag - ip;
        rv = ip;
        if (rn && (fr > 0.5 || (fr == 0.5 && $floor(ip / 2.0) * 2.0 != ip)))
            rv = ip + 1.0;
        v = a[31] ? -rv : rv;
        if (ex == 255) begin
            if (a[22:0] != 0) begin
                v = hi; fl = 3'b100;
            end else begin
                v = a[31] ? lo : hi; fl = 3'b110;
            end
        end else if (v > hi) begin
            v = hi; fl = 3'b110;
        end else if (v < lo) begin
            v = lo; fl = 3'b110;
        end else begin
            fl = {2'b00, fr != 0.0};
        end
        t = 64'(longint'(v));
        return {fl, t[32:0]};
    endfunction

    function automatic logic [31:0] rnd_a();
        logic [31:0] r;
        logic [31:0] sp [12];
        sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
               32'h7FC00001, 32'h00000001, 32'h807FFFFF, 32'h4F800000,
               32'hCF800000, 32'h4F7FFFFF, 32'hCF000000, 32'h4FFFFFFF};
        r = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: r[30:23] = 8'($urandom_range(118, 162));
            2: begin
                r[30:23] = 8'($urandom_range(126, 133));
                r[19:0]  = '0;
            end
            default: r = sp[$urandom_range(0, 11)];
        endcase
        return r;
    endfunction

    // Called at a negedge; drives one cycle and checks the output side.
    task automatic cyc(input bit v, input logic [31:0] a, input bit sg,
                       input bit rn, input bit ordy, input bit use_k,
                       input logic [35:0] k, output bit acc);
        logic [35:0] f;
        in_valid  = v;
        in_a      = a;
        in_signed = sg;
        in_rne    = rn;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (out_valid) begin
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                f = exp_q[0];
                chk("out_q", 64'(out_q), 64'(f[32:0]));
                chk("out_flags", 64'(out_flags), 64'(f[35:33]));
                if (ordy) void'(exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back(use_k ? k : model(a, sg, rn));
        @(negedge clk);
    endtask

    logic [31:0] d_a [20] = '{
        32'h406CCCCD, 32'h406CCCCD, 32'h40200000, 32'h40600000,
        32'hBF800000, 32'hBF800000, 32'h7FC00000, 32'h53800000,
        32'hFF800000, 32'h80000000, 32'h00000001, 32'hBF000000,
        32'h7F800000, 32'h4F800000, 32'hCF800000, 32'h4F7FFFFF,
        32'h3FC00000, 32'h3F000000, 32'h00000001, 32'hBFC00000};
    logic [1:0] d_m [20] = '{
        2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00,
        2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
        2'b11, 2'b11, 2'b10, 2'b11};
    logic [35:0] d_e [20] = '{
        {3'b001, 33'h000000003}, {3'b001, 33'h000000004},
        {3'b001, 33'h000000002}, {3'b001, 33'h000000004},
        {3'b000, 33'h1FFFFFFFF}, {3'b110, 33'h000000000},
        {3'b100, 33'h0FFFFFFFF}, {3'b110, 33'h1FFFFFFFF},
        {3'b110, 33'h100000000}, {3'b000, 33'h000000000},
        {3'b001, 33'h000000000}, {3'b001, 33'h000000000},
        {3'b110, 33'h1FFFFFFFF}, {3'b110, 33'h0FFFFFFFF},
        {3'b000, 33'h100000000}, {3'b000, 33'h0FFFFFF00},
        {3'b001, 33'h000000002}, {3'b001, 33'h000000000},
        {3'b001, 33'h000000000}, {3'b001, 33'h1FFFFFFFE}};

    initial begin
        bit acc;
        bit saw;
        int n;
        areset    = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_signed = 1'b0;
        in_rne    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_q", 64'(out_q), 64'd0);
        chk("rst_flags", 64'(out_flags), 64'd0);
        areset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Latency of one isolated beat
        cyc(1, 32'h40400000, 1, 0, 1, 0, '0, acc);
        chk("lat_c1", 64'(out_valid), 64'd0);
        cyc(0, '0, 0, 0, 1, 0, '0, acc);
        chk("lat_c2", 64'(out_valid), 64'd0);
        cyc(0, '0, 0, 0, 1, 0, '0, acc);
        chk("lat_c3", 64'(out_valid), 64'd1);
        cyc(0, '0, 0, 0, 1, 0, '0, acc);

        // Directed conversions with fixed expectations
        for (int i = 0; i < 20; i++)
            cyc(1, d_a[i], d_m[i][1], d_m[i][0], 1, 1, d_e[i], acc);
        for (int i = 0; i < 8; i++)
            cyc(0, '0, 0, 0, 1, 0, '0, acc);
        chk("dir_drained", 64'(exp_q.size()), 64'd0);

        // Six back-to-back beats with a consumer stall in cycles 4..8
        n   = 0;
        saw = 1'b0;
        for (int c = 1; c <= 60 && (n < 6 || exp_q.size() != 0); c++) begin
            bit vv;
            bit oo;
            vv = (n < 6);
            oo = !(c >= 4 && c <= 8);
            cyc(vv, rnd_a(), 1'($urandom), 1'($urandom), oo, 0, '0, acc);
            if (vv && !acc) saw = 1'b1;
            if (acc) n++;
        end
        chk("stall_ready_drop", 64'(saw), 64'd1);
        chk("stall_count", 64'(n), 64'd6);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++)
            cyc(1, rnd_a(), 1'($urandom), 1'($urandom), 0, 0, '0, acc);
        areset = 1'b1;
        cyc(0, '0, 0, 0, 0, 0, '0, acc);
        exp_q.delete();
        areset = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 10; i++)
            cyc(0, '0, 0, 0, 1, 0, '0, acc);

        // Random traffic with random back-pressure
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 9) < 7), rnd_a(), 1'($urandom),
                1'($urandom), ($urandom_range(0, 9) < 7), 0, '0, acc);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            cyc(0, '0, 0, 0, 1, 0, '0, acc);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
